// File: rtl/nv_nvdla_cvif_read_cq.sv
// Per-thread context queue for the CVIF read path: one independent FIFO
// partition per AXI thread id, written by the read ingress, popped by egress.

module nv_nvdla_cvif_read_cq_thread #(
    parameter int DEPTH = 8,
    parameter int PD_W  = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [PD_W-1:0] wr_pd,
    input  logic            rd_en,
    output logic [PD_W-1:0] head_pd,
    output logic            full,
    output logic            has_data,
    output logic            empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PD_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt, cnt_nxt;

    // Context storage carries no reset; a zero count makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_pd;
    end

    assign head_pd  = mem[rd_ptr];
    assign full     = (cnt == CW'(DEPTH));
    assign has_data = (cnt != '0);
    assign cnt_nxt  = cnt + CW'(wr_en) - CW'(rd_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == '0);
        end
    end
endmodule

module nv_nvdla_cvif_read_cq #(
    parameter int THREADS = 10,
    parameter int DEPTH   = 8,
    parameter int PD_W    = 7
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic               cq_wr_pvld,
    output logic               cq_wr_prdy,
    input  logic [3:0]         cq_wr_thread_id,
    input  logic [PD_W-1:0]    cq_wr_pd,
    input  logic [3:0]         cq_rd_thread_id,
    output logic               cq_rd_pvld,
    input  logic               cq_rd_prdy,
    output logic [PD_W-1:0]    cq_rd_pd,
    output logic [THREADS-1:0] cq_empty,
    output logic               cq_err
);
    localparam int ID_W = 4;

    logic [THREADS-1:0]           wr_sel, rd_sel, wr_en, rd_en, full, has_data;
    logic [THREADS-1:0][PD_W-1:0] head_pd;

    // One-hot decode; an out-of-range id simply selects nothing.
    for (genvar t = 0; t < THREADS; t++) begin : g_thr
        assign wr_sel[t] = (cq_wr_thread_id == ID_W'(t));
        assign rd_sel[t] = (cq_rd_thread_id == ID_W'(t));
        assign wr_en[t]  = wr_sel[t] & cq_wr_pvld & cq_wr_prdy;
        assign rd_en[t]  = rd_sel[t] & cq_rd_pvld & cq_rd_prdy;

        nv_nvdla_cvif_read_cq_thread #(.DEPTH(DEPTH), .PD_W(PD_W)) u_thr (
            .clk      (nvdla_core_clk),
            .rst      (nvdla_core_rst),
            .wr_en    (wr_en[t]),
            .wr_pd    (cq_wr_pd),
            .rd_en    (rd_en[t]),
            .head_pd  (head_pd[t]),
            .full     (full[t]),
            .has_data (has_data[t]),
            .empty    (cq_empty[t])
        );
    end

    // Full threads refuse writes even when popped this cycle (no pass-through).
    assign cq_wr_prdy = |(wr_sel & ~full);
    assign cq_rd_pvld = |(rd_sel & has_data);

    always_comb begin
        cq_rd_pd = '0;
        for (int t = 0; t < THREADS; t++) begin
            if (rd_sel[t] && has_data[t]) cq_rd_pd = head_pd[t];
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            cq_err <= 1'b0;
        end else if ((cq_wr_pvld && !(|wr_sel)) || (cq_rd_prdy && !cq_rd_pvld)) begin
            cq_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nv_nvdla_cvif_read_cq.sv
// Bench for the per-thread context queue: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.

module tb_nv_nvdla_cvif_read_cq;
    localparam int T = 10;
    localparam int D = 8;
    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_pvld, wr_prdy, rd_pvld, rd_prdy, err;
    logic [3:0]   wr_id, rd_id;
    logic [W-1:0] wr_pd, rd_pd;
    logic [T-1:0] empty;

    always #5 clk = ~clk;

    nv_nvdla_cvif_read_cq #(.THREADS(T), .DEPTH(D), .PD_W(W)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rst  (rst),
        .cq_wr_pvld      (wr_pvld),
        .cq_wr_prdy      (wr_prdy),
        .cq_wr_thread_id (wr_id),
        .cq_wr_pd        (wr_pd),
        .cq_rd_thread_id (rd_id),
        .cq_rd_pvld      (rd_pvld),
        .cq_rd_prdy      (rd_prdy),
        .cq_rd_pd        (rd_pd),
        .cq_empty        (empty),
        .cq_err          (err)
    );

    // Reference: one queue per thread plus a sticky error bit.
    logic [W-1:0] mq [T][$];
    bit           merr;
    int           checks = 0;
    int           fails  = 0;

    typedef struct {
        bit           wv;
        bit [3:0]     wid;
        bit [W-1:0]   wpd;
        bit [3:0]     rid;
        bit           rp;
        bit           e_prdy;
        bit           e_pvld;
        bit [W-1:0]   e_pd;
    } vec_t;
    vec_t tv [8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_prdy(input logic [3:0] id);
        return (id < T) && (mq[id].size() < D);
    endfunction

    function automatic bit m_pvld(input logic [3:0] id);
        return (id < T) && (mq[id].size() > 0);
    endfunction

    function automatic logic [W-1:0] m_pd(input logic [3:0] id);
        return m_pvld(id) ? mq[id][0] : '0;
    endfunction

    function automatic logic [T-1:0] m_empty();
        logic [T-1:0] e;
        for (int t = 0; t < T; t++) e[t] = (mq[t].size() == 0);
        return e;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < T; t++) mq[t].delete();
        merr = 1'b0;
    endtask

    // Called just after a rising edge; checks combinational outputs vs model.
    task automatic drive(input bit wv, input logic [3:0] wid, input logic [W-1:0] wpd,
                         input logic [3:0] rid, input bit rp);
        wr_pvld = wv; wr_id = wid; wr_pd = wpd; rd_id = rid; rd_prdy = rp;
        #1;
        chk("m_wr_prdy", wr_prdy, m_prdy(wid));
        chk("m_rd_pvld", rd_pvld, m_pvld(rid));
        chk("m_rd_pd",   rd_pd,   m_pd(rid));
    endtask

    task automatic tick();
        bit wf, rf;
        wf = wr_pvld && m_prdy(wr_id);
        rf = rd_prdy && m_pvld(rd_id);
        if ((wr_pvld && wr_id >= T) || (rd_prdy && !m_pvld(rd_id))) merr = 1'b1;
        @(posedge clk);
        if (rf) void'(mq[rd_id].pop_front());
        if (wf) mq[wr_id].push_back(wr_pd);
        #1;
        chk("m_empty", empty, m_empty());
        chk("m_err",   err,   merr);
    endtask

    task automatic drain(input logic [3:0] t);
        for (int n = 0; n < 2 * D && mq[t].size() > 0; n++) begin
            drive(0, t, '0, t, 1);
            tick();
        end
        chk("drain_empty", empty[t], 1);
    endtask

    initial begin
        tv[0] = '{0, 4'd3,  7'h00, 4'd0, 0, 1, 0, 7'h00};
        tv[1] = '{0, 4'd12, 7'h00, 4'd9, 0, 0, 0, 7'h00};
        tv[2] = '{1, 4'd2,  7'h11, 4'd2, 0, 1, 0, 7'h00};
        tv[3] = '{1, 4'd2,  7'h22, 4'd2, 0, 1, 1, 7'h11};
        tv[4] = '{1, 4'd2,  7'h33, 4'd2, 1, 1, 1, 7'h11};
        tv[5] = '{0, 4'd2,  7'h00, 4'd2, 1, 1, 1, 7'h22};
        tv[6] = '{0, 4'd2,  7'h00, 4'd2, 1, 1, 1, 7'h33};
        tv[7] = '{0, 4'd2,  7'h00, 4'd2, 0, 1, 0, 7'h00};

        rst = 1'b1; wr_pvld = 0; wr_id = 0; wr_pd = 0; rd_id = 0; rd_prdy = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", empty, 10'h3FF);
        chk("rst_err",   err,   0);
        chk("rst_pvld",  rd_pvld, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Vector table: reset idle, then ordered writes/pops on thread 2.
        foreach (tv[i]) begin
            drive(tv[i].wv, tv[i].wid, tv[i].wpd, tv[i].rid, tv[i].rp);
            chk("tbl_prdy", wr_prdy, tv[i].e_prdy);
            chk("tbl_pvld", rd_pvld, tv[i].e_pvld);
            chk("tbl_pd",   rd_pd,   tv[i].e_pd);
            tick();
        end
        chk("t2_empty_end", empty[2], 1);
        for (int t = 0; t < T; t++) begin
            drive(0, 4'(t), '0, 4'(t), 0);
            chk("idle_pvld", rd_pvld, 0);
        end

        // Fill thread 5, popping while full must not let a write through.
        for (int i = 0; i < D; i++) begin drive(1, 5, 7'(8'h50 + i), 5, 0); tick(); end
        drive(1, 5, 7'h7F, 5, 1);
        chk("full_prdy", wr_prdy, 0);
        chk("full_pvld", rd_pvld, 1);
        chk("full_pd",   rd_pd,   7'h50);
        tick();
        for (int i = 0; i < 2; i++) begin drive(0, 5, '0, 5, 1); tick(); end
        for (int i = 0; i < 3; i++) begin drive(1, 5, 7'(8'h58 + i), 5, 0); tick(); end
        for (int i = 0; i < D; i++) begin
            drive(0, 5, '0, 5, 1);
            chk("wrap_order", rd_pd, 7'(8'h53 + i));
            tick();
        end
        chk("t5_empty", empty[5], 1);

        // Thread 7 at steady occupancy 4 with a write and pop every cycle.
        for (int i = 0; i < 4; i++) begin drive(1, 7, 7'(8'h70 + i), 7, 0); tick(); end
        for (int i = 0; i < 20; i++) begin
            drive(1, 7, 7'(8'h74 + i), 7, 1);
            chk("same_thr_pd", rd_pd, 7'(8'h70 + i));
            tick();
        end
        chk("same_thr_cnt", mq[7].size(), 4);
        chk("t7_nonempty", empty[7], 0);
        drain(7);

        // Thread 0 full and stalled while thread 9 streams at full rate.
        for (int i = 0; i < D; i++) begin drive(1, 0, 7'(8'h60 + i), 0, 0); tick(); end
        drive(1, 9, 7'h40, 9, 0); tick();
        for (int i = 0; i < 16; i++) begin
            drive(1, 9, 7'(8'h41 + i), 9, 1);
            chk("iso_prdy", wr_prdy, 1);
            chk("iso_pvld", rd_pvld, 1);
            tick();
        end
        drain(9);
        for (int i = 0; i < D; i++) begin
            drive(0, 0, '0, 0, 1);
            chk("iso_t0_data", rd_pd, 7'(8'h60 + i));
            tick();
        end

        // Errors: out-of-range write, then pop of an empty thread.
        drive(1, 11, 7'h2A, 0, 0);
        chk("oor_prdy", wr_prdy, 0);
        tick();
        chk("oor_err",  err, 1);
        chk("oor_none", empty, 10'h3FF);
        drive(0, 0, '0, 3, 1); tick();
        chk("pop_empty_err", err, 1);

        // Asynchronous reset with three threads partly full.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 7'(i), 1, 0); tick();
            drive(1, 4, 7'(i), 4, 0); tick();
            drive(1, 6, 7'(i), 6, 0); tick();
        end
        chk("pre_rst_empty", empty, 10'h3AD);
        drive(0, 0, '0, 4, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_empty", empty, 10'h3FF);
        chk("async_rst_err",   err,   0);
        chk("async_rst_pvld",  rd_pvld, 0);
        chk("async_rst_pd",    rd_pd,   0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic, biased to a few threads so fullness is reached.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] wid, rid;
            wid = ($urandom % 8 == 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 2));
            rid = ($urandom % 8 == 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 2));
            drive(bit'($urandom % 4 != 0), wid, 7'($urandom), rid,
                  bit'(($urandom % 3 == 0) && (n > 300 || m_pvld(rid))));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/nv_nvdla_cvif_read_cq.md
# nv_nvdla_cvif_read_cq

Per-thread context queue for the CVIF read path. It sits between the read ingress, which writes one 7-bit context word per issued AXI AR burst tagged with a 4-bit thread id, and the read egress, which pops the context of the oldest outstanding burst of a given thread when its data returns. Each thread has its own fixed-size FIFO partition, so one stalled thread never blocks another.

## Interface
Parameters:
- THREADS, 10, number of thread partitions; valid thread ids are 0..THREADS-1.
- DEPTH, 8, entries per thread; must be a power of 2 and at least 2.
- PD_W, 7, context word width.

Ports:
- nvdla_core_clk  in  1  core clock; all state is on the rising edge.
- nvdla_core_rst  in  1  reset, asynchronous assert, active-high.
- cq_wr_pvld  in  1  write valid.
- cq_wr_prdy  out  1  write ready. Combinational: 1 when cq_wr_thread_id is below THREADS and that thread's count is below DEPTH.
- cq_wr_thread_id  in  4  write thread id.
- cq_wr_pd  in  PD_W  write context word.
- cq_rd_thread_id  in  4  read thread select, driven by the egress.
- cq_rd_pvld  out  1  Combinational: 1 when cq_rd_thread_id is below THREADS and that thread's count is nonzero.
- cq_rd_prdy  in  1  pop strobe; acts only when cq_rd_pvld is 1.
- cq_rd_pd  out  PD_W  head entry of the selected thread; forced to 0 when cq_rd_pvld is 0.
- cq_empty  out  THREADS  registered per-thread empty flags.
- cq_err  out  1  registered sticky error flag.

## Operation
- State per thread t:
  - wr_ptr[t] and rd_ptr[t], each log2(DEPTH) bits, wrapping modulo DEPTH.
  - cnt[t], log2(DEPTH)+1 bits, range 0..DEPTH.
- Storage: THREADS*DEPTH*PD_W flops, not reset.
- Write fire (cq_wr_pvld & cq_wr_prdy):
  - mem[id][wr_ptr[id]] <= cq_wr_pd.
  - wr_ptr[id] increments.
- Read fire (cq_rd_pvld & cq_rd_prdy): rd_ptr[id] increments.
- cnt[t] next value: +1 on a write fire to t only, -1 on a read fire from t only, unchanged when both or neither fire on t.
- Same thread written and read in one cycle:
  - Count is unchanged; both pointers advance.
  - Legal only when the thread holds at least 1 and at most DEPTH-1 entries. At 0, pvld is 0; at DEPTH, prdy is 0.
- No bypass: a word written to an empty thread is not visible on cq_rd_pd in the cycle it is written.
- No pass-through on full: a full thread has cq_wr_prdy=0 even if that thread is popped in the same cycle.
- Different threads written and read in the same cycle: fully independent.
- Out-of-range id (at or above THREADS):
  - Write side: prdy=0.
  - Read side: pvld=0, pd=0.
  - Error: cq_err sets if cq_wr_pvld=1 with an out-of-range id, or cq_rd_prdy=1 while cq_rd_pvld=0.
  - cq_err clears only on reset.
- cq_empty[t] is registered from the next-state value of cnt[t], so it reflects the count at the end of each cycle.

## Timing
- Reset values while nvdla_core_rst=1 and after release:
  - All cnt, wr_ptr and rd_ptr are 0.
  - cq_empty = all 1s; cq_err = 0.
  - cq_rd_pvld = 0; cq_rd_pd = 0.
  - cq_wr_prdy = 1 for any in-range id.
- Reset asserted mid-operation discards all queued contexts immediately (asynchronous). Storage contents are ignored afterwards because every count is 0.
- Write-to-read latency is 1 cycle: a word written at edge N is presented on cq_rd_pd after edge N (cycle N+1), if it is the thread head.
- cq_rd_pvld and cq_rd_pd respond combinationally to cq_rd_thread_id (mux over the head entries), so the egress may change thread every cycle.
- cq_wr_prdy has no dependency on cq_wr_pvld or on any read-side input.
- Throughput: one write and one read per cycle, on any threads.

## Test plan
- Reset then idle:
  - Expect cq_empty=10'h3FF, cq_err=0 and cq_rd_pvld=0 for ids 0..9.
  - Expect cq_wr_prdy=1 for id 3 and 0 for id 12.
- Order within a thread:
  - Write 0x11, 0x22, 0x33 to thread 2 on consecutive cycles.
  - Pop thread 2 three times; expect 0x11, 0x22, 0x33 in order.
  - pvld first asserts the cycle after the first write; cq_empty[2] ends at 1.
- Full and wrap:
  - Fill thread 5 with 8 words; expect cq_wr_prdy=0 for id 5 while pvld=1, and no pass-through when it is also popped.
  - Pop 3, write 3 more (exercises pointer wrap); drain and verify FIFO order across the wrap.
- Simultaneous same-thread:
  - With thread 7 holding 4 entries, write and pop every cycle for 20 cycles.
  - Expect the count to stay at 4 and the popped data to equal the sequence written 4 words earlier.
- Thread isolation:
  - Fill thread 0 to 8 and stall its pops; stream writes and pops on thread 9.
  - Expect thread 9 at full rate, with thread 0 data intact afterwards.
- Errors and reset:
  - Write with id 11 -> cq_err=1 next cycle, nothing stored.
  - Pop an empty thread -> cq_err stays 1.
  - Assert reset with 3 threads partly full -> all cq_empty=1 and cq_err=0 immediately.
